icache_param: RTL and testbench
===============================

# icache_param

Parametrised instruction cache between the datapath fetch port and the memory controller's instruction channel; it replaces the direct fetch passthrough. It supports set-associative configurations with multi-word blocks. Hits return data in the request cycle. Misses run a fill state machine that fetches the whole block word by word from the controller, then installs it.

## Interface
Parameters:
- SETS, 8: number of sets; power of two, 2 to 256.
- WAYS, 1: associativity; 1 (direct-mapped) or 2.
- WORDS, 2: 32-bit words per block; 1, 2 or 4.

Ports (one clock; reset is asynchronous and active-high):
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous reset, asserted high (nRST=1 resets).
- imemREN  in  1  fetch request from datapath.
- imemaddr  in  32  fetch byte address; bits [1:0] ignored.
- iflush  in  1  invalidate all lines.
- ihit  out  1  fetch data valid this cycle.
- imemload  out  32  fetched instruction.
- iREN  out  1  read request to memory controller.
- iaddr  out  32  word-aligned fill address.
- iwait  in  1  controller busy; a word is delivered when iREN=1 and iwait=0.
- iload  in  32  fill data from controller.

## Operation
- Address split: offset OB=$clog2(WORDS) bits at [OB+1:2], index IB=$clog2(SETS) bits above the offset, tag = remaining 30-IB-OB upper bits.
- Lookup (combinational, state IDLE): ihit=1 when imemREN=1, iflush=0, and some way has valid=1 with a matching tag. imemload = the selected word of the hitting way. When ihit=0, imemload=0.
- States: IDLE and FILL.
- IDLE to FILL: imemREN=1 with a miss. On the transition, latch the tag/index of imemaddr and clear the word counter.
- In FILL:
  - iREN=1.
  - iaddr = {latched tag, latched index, word counter, 2'b00}.
  - Each edge with iwait=0 stores iload in the fill buffer and increments the counter.
  - On the edge that accepts word WORDS-1:
    - write tag, data and valid=1 into the victim way;
    - update LRU;
    - return to IDLE.
- A change of imemaddr or imemREN during FILL does not affect the fill in progress. The fill always completes.
- Victim selection:
  - WAYS=1: way 0.
  - WAYS=2: the first invalid way (way 0 first); otherwise the way not most recently used.
  - A hit or a fill marks the way as most recently used.
- iflush: on the edge where iflush=1, all valid bits and LRU bits are cleared. Any FILL is aborted and the state returns to IDLE. Tag and data arrays are untouched.
- Priority: reset > iflush > fill completion > hit.

## Timing
- Reset values:
  - state IDLE, all valid bits 0, LRU bits 0, word counter 0;
  - ihit=0, imemload=0, iREN=0, iaddr=0.
- iaddr=0 whenever the state is not FILL.
- Hit latency: 0 cycles.
- Miss penalty: 1 cycle (IDLE to FILL) plus the cycles spent waiting for and accepting the WORDS words.
  - Example, WORDS=2 with iwait=0 throughout: the miss is detected in cycle 0, words are accepted in cycles 1 and 2, and ihit=1 in cycle 3.
- The installed line is visible to lookup in the cycle after the last word is accepted.
- Reset asserted mid-fill: the fill is dropped immediately and asynchronously. No partial line is installed.

## Configuration
- ICACHE_STATS_EN defined:
  - adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0;
  - hit_count increments on each cycle with ihit=1;
  - miss_count increments on each IDLE-to-FILL transition;
  - both counters saturate at 32'hFFFFFFFF and are not cleared by iflush.
- ICACHE_STATS_EN undefined: the ports and the counters are absent.

## Structure
- cpu_types_pkg gains:
  - icache_state_t (IDLE, FILL);
  - the parameter-derived width functions (tag, index and offset width from SETS and WORDS);
  - the icache_frame_t struct (valid, tag, data[WORDS]).
- One sub-module, icache_way: the valid/tag/data storage for a single way, with an asynchronously reset valid array and a tag-compare hit output. It is instantiated WAYS times. The FSM, LRU and fill buffer live in the top module.

## Test plan
- Cold miss, SETS=8 WAYS=1 WORDS=2, fetch 0x00000040, iwait=1 for 2 cycles per word:
  - iaddr shows 0x40 then 0x44;
  - ihit=1 with imemload = word 0 on the cycle after the second word;
  - a following fetch of 0x44 hits in 0 cycles.
- Conflict, WAYS=2 SETS=8 WORDS=1:
  - fill 0x000, 0x020 and 0x040 (all index 0), re-touching 0x000 before the third fill;
  - the third fill evicts 0x020, so 0x000 still hits and 0x020 misses.
- Address changes mid-fill from 0x100 to 0x200: the fill completes for 0x100, then the next IDLE cycle starts a miss for 0x200.
- iflush pulse asserted while in FILL for 0x300:
  - iREN drops the next cycle;
  - a subsequent fetch of any previously cached address misses.
- Reset asserted in the middle of the second word of a fill: all outputs are 0 immediately, and after reset the same address misses.
- With ICACHE_STATS_EN defined, 3 misses then 5 hit cycles: miss_count=3 and hit_count=5. After iflush the counts are unchanged.

Source files
------------

// File: rtl/icache_param_pkg.sv
// icache_param_pkg: shared types and width helpers for the parametrised instruction cache.
//   icache_state_t : fill FSM states (IDLE, FILL)
//   off_width / idx_width / tag_width : address field widths derived from SETS and WORDS
//   icache_frame_t : one cache line as written into a way (sized for the largest config,
//                    each way keeps only the low tag bits and the first WORDS words)
package icache_param_pkg;

  localparam int unsigned MaxWords = 4;
  localparam int unsigned MaxTagW  = 30;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

  function automatic int unsigned off_width(input int unsigned words);
    return $clog2(words);
  endfunction

  function automatic int unsigned idx_width(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_width(input int unsigned sets, input int unsigned words);
    return 30 - idx_width(sets) - off_width(words);
  endfunction

  typedef struct packed {
    logic                         valid;
    logic [MaxTagW-1:0]           tag;
    logic [MaxWords-1:0][31:0]    data;
  } icache_frame_t;

endpackage

// File: rtl/icache_param_if.sv
// icache_param_if: fetch-port and fill-channel signals of the instruction cache.
//   Datapath side : imemREN, imemaddr, iflush -> cache ; ihit, imemload <- cache
//   Memory side   : iREN, iaddr <- cache ; iwait, iload -> cache
// Modports: master (datapath + memory controller view), slave (cache view).
interface icache_param_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_way.sv
// icache_way: valid/tag/data storage for one way of the instruction cache.
//   clk_i, rst_i   : clock, asynchronous active-high reset (clears valid bits only)
//   flush_i        : clear all valid bits on the next edge
//   rd_idx_i/rd_tag_i -> hit_o, valid_o, rd_data_o : combinational lookup of one set
//   we_i, wr_idx_i, wr_frame_i : install a whole line
module icache_way
  import icache_param_pkg::*;
#(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WORDS = 2,
  localparam int unsigned IW = idx_width(SETS),
  localparam int unsigned TW = tag_width(SETS, WORDS)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [IW-1:0]          rd_idx_i,
  input  logic [TW-1:0]          rd_tag_i,
  input  logic                   we_i,
  input  logic [IW-1:0]          wr_idx_i,
  input  icache_frame_t          wr_frame_i,
  output logic                   hit_o,
  output logic                   valid_o,
  output logic [WORDS-1:0][31:0] rd_data_o
);

  logic [SETS-1:0]          valid_q;
  logic [TW-1:0]            tag_q  [SETS];
  logic [WORDS-1:0][31:0]   data_q [SETS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_idx_i] <= wr_frame_i.valid;
    end
  end

  // Tag and data arrays carry no reset; valid gates every use.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_frame_i.tag[TW-1:0];
      data_q[wr_idx_i] <= wr_frame_i.data[WORDS-1:0];
    end
  end

  assign valid_o   = valid_q[rd_idx_i];
  assign hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i];

  // Frame is sized for the largest configuration; the upper bits are dropped here.
  logic unused_frame;
  assign unused_frame = ^{wr_frame_i.tag, wr_frame_i.data};

endmodule

// File: rtl/icache_param.sv
// icache_param: parametrised instruction cache (SETS x WAYS, WORDS words per line).
//   CLK, nRST : clock, asynchronous active-high reset
//   bus       : icache_param_if.slave (fetch port and fill channel)
// Optional feature macro ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
// Hits answer combinationally in IDLE; a miss fills the line word by word in FILL.
module icache_param
  import icache_param_pkg::*;
#(
  parameter int unsigned SETS  = 8,
  parameter int unsigned WAYS  = 1,
  parameter int unsigned WORDS = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  icache_param_if.slave      bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]        hit_count,
  output logic [31:0]        miss_count
`endif
);

  localparam int unsigned OB = off_width(WORDS);
  localparam int unsigned IB = idx_width(SETS);
  localparam int unsigned TW = tag_width(SETS, WORDS);
  localparam int unsigned CW = (OB > 0) ? OB : 1;

  icache_state_t          state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IB-1:0]          fill_idx_q, fill_idx_d;
  logic [TW-1:0]          fill_tag_q, fill_tag_d;
  logic                   victim_q, victim_d;
  logic [WORDS-1:0][31:0] buf_q, buf_d;
  logic [SETS-1:0]        lru_q, lru_d;  // per set: most recently used way

  logic [IB-1:0]          req_idx;
  logic [TW-1:0]          req_tag;
  logic [CW-1:0]          req_off;

  logic [WAYS-1:0]        way_hit, way_valid, way_we;
  logic [WORDS-1:0][31:0] way_data [WAYS];
  logic [1:0]             vld2;
  logic                   any_hit, hit_way, victim_sel;
  logic [32*WORDS-1:0]    hit_line;
  logic [31:0]            hit_word;
  logic                   fill_done, miss_start;
  icache_frame_t          frame;

  assign req_idx = bus.imemaddr[2+OB +: IB];
  assign req_tag = bus.imemaddr[31 -: TW];
  assign req_off = CW'((bus.imemaddr >> 2) & 32'(WORDS - 1));
  assign any_hit = |way_hit;
  assign vld2    = 2'(way_valid);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign way_we[w] = fill_done && (victim_q == 1'(w));

    icache_way #(
      .SETS  (SETS),
      .WORDS (WORDS)
    ) u_way (
      .clk_i      (CLK),
      .rst_i      (nRST),
      .flush_i    (bus.iflush),
      .rd_idx_i   (req_idx),
      .rd_tag_i   (req_tag),
      .we_i       (way_we[w]),
      .wr_idx_i   (fill_idx_q),
      .wr_frame_i (frame),
      .hit_o      (way_hit[w]),
      .valid_o    (way_valid[w]),
      .rd_data_o  (way_data[w])
    );
  end

  always_comb begin
    hit_way  = 1'b0;
    hit_line = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit_way  = 1'(w);
        hit_line = way_data[w];
      end
    end
    hit_word = hit_line[32*req_off +: 32];
  end

  // First invalid way wins, else the way that was not used last.
  always_comb begin
    victim_sel = 1'b0;
    if (WAYS > 1) begin
      if (!vld2[0])      victim_sel = 1'b0;
      else if (!vld2[1]) victim_sel = 1'b1;
      else               victim_sel = ~lru_q[req_idx];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    fill_idx_d   = fill_idx_q;
    fill_tag_d   = fill_tag_q;
    victim_d     = victim_q;
    buf_d        = buf_q;
    lru_d        = lru_q;
    fill_done    = 1'b0;
    miss_start   = 1'b0;
    bus.ihit     = 1'b0;
    bus.imemload = '0;
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;

    case (state_q)
      IDLE: begin
        if (bus.imemREN && !bus.iflush) begin
          if (any_hit) begin
            bus.ihit       = 1'b1;
            bus.imemload   = hit_word;
            lru_d[req_idx] = hit_way;
          end else begin
            state_d    = FILL;
            miss_start = 1'b1;
            fill_idx_d = req_idx;
            fill_tag_d = req_tag;
            cnt_d      = '0;
            victim_d   = victim_sel;
          end
        end
      end
      FILL: begin
        bus.iREN  = 1'b1;
        bus.iaddr = (32'({fill_tag_q, fill_idx_q}) << (OB + 2)) | (32'(cnt_q) << 2);
        if (!bus.iwait) begin
          for (int i = 0; i < WORDS; i++) begin
            if (cnt_q == CW'(i)) buf_d[i] = bus.iload;
          end
          if (cnt_q == CW'(WORDS - 1)) begin
            fill_done         = 1'b1;
            state_d           = IDLE;
            cnt_d             = '0;
            lru_d[fill_idx_q] = victim_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush beats everything: abort any fill, forget recency.
    if (bus.iflush) begin
      state_d   = IDLE;
      cnt_d     = '0;
      lru_d     = '0;
      fill_done = 1'b0;
    end
  end

  // Installed line takes the word arriving this cycle straight from buf_d.
  always_comb begin
    frame       = '0;
    frame.valid = 1'b1;
    frame.tag   = MaxTagW'(fill_tag_q);
    for (int i = 0; i < WORDS; i++) frame.data[i] = buf_d[i];
  end

  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      victim_q   <= 1'b0;
      buf_q      <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_idx_q <= fill_idx_d;
      fill_tag_q <= fill_tag_d;
      victim_q   <= victim_d;
      buf_q      <= buf_d;
      lru_q      <= lru_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating; iflush does not touch them.
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (bus.ihit && (hit_cnt_q != '1))    hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_start && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = miss_start;
`endif

  logic unused_addr;
  assign unused_addr = ^bus.imemaddr[1:0];

endmodule

// File: tb/tb_icache_param.sv
// tb_icache_param: self-checking bench for icache_param (SETS=8, WAYS=2, WORDS=2).
// A line-level reference model (valid lines per set, MRU way, pending fill) predicts
// ihit/imemload/iREN/iaddr every cycle; memory contents come from a fixed hash.
module tb_icache_param;
  localparam int unsigned Sets      = 8;
  localparam int unsigned Ways      = 2;
  localparam int unsigned Words     = 2;
  localparam int unsigned LineBytes = 4 * Words;

  logic clk;
  logic rst;
  icache_param_if bus ();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_param #(
    .SETS  (Sets),
    .WAYS  (Ways),
    .WORDS (Words)
  ) u_dut (
    .CLK        (clk),
    .nRST       (rst),
    .bus        (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic        m_valid [Sets][Ways];
  logic [31:0] m_line  [Sets][Ways];
  int          m_mru   [Sets];
  logic        m_fill;
  logic [31:0] m_base;
  int          m_n;
  int          m_hits;
  int          m_misses;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic int set_of(input logic [31:0] a);
    return int'((a / LineBytes) % Sets);
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a - (a % LineBytes);
  endfunction

  function automatic logic model_lookup(input logic [31:0] a, output int way);
    way = 0;
    for (int w = 0; w < Ways; w++) begin
      if (m_valid[set_of(a)][w] && m_line[set_of(a)][w] == line_of(a)) begin
        way = w;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  task automatic model_flush();
    for (int s = 0; s < Sets; s++) begin
      m_mru[s] = 0;
      for (int w = 0; w < Ways; w++) m_valid[s][w] = 1'b0;
    end
    m_fill = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    m_base   = '0;
    m_n      = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_update(input logic req, input logic [31:0] addr, input logic flush,
                              input logic wt);
    int w;
    int s;
    if (flush) begin
      model_flush();
    end else if (m_fill) begin
      if (!wt) begin
        m_n++;
        if (m_n == Words) begin
          s = set_of(m_base);
          if (!m_valid[s][0])      w = 0;
          else if (!m_valid[s][1]) w = 1;
          else                     w = 1 - m_mru[s];
          m_valid[s][w] = 1'b1;
          m_line[s][w]  = m_base;
          m_mru[s]      = w;
          m_fill        = 1'b0;
        end
      end
    end else if (req) begin
      if (model_lookup(addr, w)) begin
        m_mru[set_of(addr)] = w;
        m_hits++;
      end else begin
        m_fill = 1'b1;
        m_base = line_of(addr);
        m_n    = 0;
        m_misses++;
      end
    end
  endtask

  // One clock cycle: drive, check mid-cycle against the model, advance on the edge.
  task automatic step(input logic req, input logic [31:0] addr, input logic flush,
                      input logic wt, output logic obs_hit);
    logic        e_hit;
    logic [31:0] e_load;
    logic [31:0] e_addr;
    int          w;
    bus.imemREN  = req;
    bus.imemaddr = addr;
    bus.iflush   = flush;
    bus.iwait    = wt;
    bus.iload    = m_fill ? mem_word(m_base + 32'(4 * m_n)) : $urandom;
    e_addr = m_fill ? m_base + 32'(4 * m_n) : 32'h0;
    e_hit  = !m_fill && req && !flush && model_lookup(addr, w);
    e_load = e_hit ? mem_word({addr[31:2], 2'b00}) : 32'h0;
    #3;
    check_eq("ihit", bus.ihit, e_hit);
    check_eq("imemload", bus.imemload, e_load);
    check_eq("iREN", bus.iREN, m_fill);
    check_eq("iaddr", bus.iaddr, e_addr);
    obs_hit = bus.ihit;
    @(posedge clk);
    model_update(req, addr, flush, wt);
    #1;
  endtask

  // Request one address until it hits, bounded.
  task automatic fetch(input logic [31:0] a, input bit rnd_wait, output logic hit_first);
    logic h;
    int   n;
    step(1'b1, a, 1'b0, rnd_wait ? ($urandom_range(0, 2) == 0) : 1'b0, h);
    hit_first = h;
    n = 0;
    while (!h && n < 40) begin
      step(1'b1, a, 1'b0, rnd_wait ? ($urandom_range(0, 2) == 0) : 1'b0, h);
      n++;
    end
    check_eq("fetch_bound", h, 1'b1);
  endtask

  task automatic do_reset();
    bus.imemREN = 1'b0;
    bus.iflush  = 1'b0;
    bus.iwait   = 1'b0;
    rst         = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  logic        h;
  logic [31:0] pool [6];

  initial begin
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst          = 1'b1;
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h40;
    bus.iflush   = 1'b0;
    bus.iwait    = 1'b0;
    bus.iload    = 32'hDEAD_BEEF;
    #12;
    check_eq("rst_ihit", bus.ihit, 1'b0);
    check_eq("rst_imemload", bus.imemload, 32'h0);
    check_eq("rst_iREN", bus.iREN, 1'b0);
    check_eq("rst_iaddr", bus.iaddr, 32'h0);
    bus.imemREN = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss at 0x40, two wait cycles before each word.
    step(1'b1, 32'h40, 1'b0, 1'b0, h);
    check_eq("cold_miss", h, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 32'h40, 1'b0, 1'b1, h);
      step(1'b1, 32'h40, 1'b0, 1'b1, h);
      step(1'b1, 32'h40, 1'b0, 1'b0, h);
    end
    step(1'b1, 32'h40, 1'b0, 1'b0, h);
    check_eq("cold_hit_w0", h, 1'b1);
    step(1'b1, 32'h44, 1'b0, 1'b0, h);
    check_eq("cold_hit_w1", h, 1'b1);

    // Conflict in set 0 with LRU replacement.
    step(1'b0, 32'h0, 1'b1, 1'b0, h);
    fetch(32'h000, 1'b0, h);  check_eq("cf_a_miss", h, 1'b0);
    fetch(32'h040, 1'b0, h);  check_eq("cf_b_miss", h, 1'b0);
    fetch(32'h000, 1'b0, h);  check_eq("cf_a_touch", h, 1'b1);
    fetch(32'h080, 1'b0, h);  check_eq("cf_c_miss", h, 1'b0);
    fetch(32'h000, 1'b0, h);  check_eq("cf_a_kept", h, 1'b1);
    fetch(32'h040, 1'b0, h);  check_eq("cf_b_evicted", h, 1'b0);

    // Address changes mid-fill: 0x100 still completes, then 0x200 misses.
    step(1'b1, 32'h100, 1'b0, 1'b0, h);
    step(1'b1, 32'h200, 1'b0, 1'b0, h);
    step(1'b1, 32'h200, 1'b0, 1'b0, h);
    step(1'b1, 32'h200, 1'b0, 1'b0, h);
    check_eq("chg_new_miss", h, 1'b0);
    fetch(32'h200, 1'b0, h);
    fetch(32'h100, 1'b0, h);  check_eq("chg_old_installed", h, 1'b1);

    // Flush during a fill of 0x300.
    step(1'b1, 32'h300, 1'b0, 1'b0, h);
    step(1'b1, 32'h300, 1'b1, 1'b1, h);
    step(1'b0, 32'h0, 1'b0, 1'b0, h);
    step(1'b1, 32'h100, 1'b0, 1'b0, h);
    check_eq("flush_miss", h, 1'b0);
    fetch(32'h100, 1'b0, h);

    // Reset in the middle of the second word.
    step(1'b1, 32'h400, 1'b0, 1'b0, h);
    step(1'b1, 32'h400, 1'b0, 1'b0, h);
    bus.iwait = 1'b1;
    bus.iload = mem_word(32'h404);
    #2;
    check_eq("rstm_iaddr_before", bus.iaddr, 32'h404);
    rst = 1'b1;
    #1;
    check_eq("rstm_ihit", bus.ihit, 1'b0);
    check_eq("rstm_imemload", bus.imemload, 32'h0);
    check_eq("rstm_iREN", bus.iREN, 1'b0);
    check_eq("rstm_iaddr", bus.iaddr, 32'h0);
    model_reset();
    bus.imemREN = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 32'h400, 1'b0, 1'b0, h);
    check_eq("rstm_refill_miss", h, 1'b0);
    fetch(32'h400, 1'b0, h);

    // Three misses, five hit cycles from a clean reset.
    do_reset();
    fetch(32'h000, 1'b0, h);
    fetch(32'h008, 1'b0, h);
    fetch(32'h010, 1'b0, h);
    step(1'b1, 32'h000, 1'b0, 1'b0, h);
    step(1'b1, 32'h00C, 1'b0, 1'b0, h);
`ifdef ICACHE_STATS_EN
    check_eq("stat_miss", miss_count, 32'd3);
    check_eq("stat_hit", hit_count, 32'd5);
    step(1'b0, 32'h0, 1'b1, 1'b0, h);
    check_eq("stat_miss_flush", miss_count, 32'd3);
    check_eq("stat_hit_flush", hit_count, 32'd5);
`endif

    // Randomised traffic over a small pool of lines that collide in a few sets.
    pool[0] = 32'h000; pool[1] = 32'h040; pool[2] = 32'h080;
    pool[3] = 32'h008; pool[4] = 32'h048; pool[5] = 32'h100;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 8,
           pool[$urandom_range(0, 5)] + 32'(4 * $urandom_range(0, 1)) + 32'($urandom_range(0, 3)),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 9) < 3,
           h);
    end
`ifdef ICACHE_STATS_EN
    check_eq("rnd_stat_hit", hit_count, 32'(m_hits));
    check_eq("rnd_stat_miss", miss_count, 32'(m_misses));
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
